// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, constants and index helper for the loadable instruction memory
package imem_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    // Fetch addresses are widened to IDX_W before the range check so that
    // high address bits can never alias back into the array.
    localparam int IDX_W = 64;

    function automatic logic [IDX_W-1:0] fetch_index(input logic [IDX_W-1:0] addr,
                                                      input bit               byte_addr);
        return byte_addr ? (addr >> 2) : addr;
    endfunction

endpackage

// File: rtl/imem_loadable_if.sv
// rtl/imem_loadable_if.sv - load stream and fetch port bundle between fetch stage and instruction memory
interface imem_loadable_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              run_mode;

    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic              stall;
    logic              flush;

    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              addr_fault;

    modport master (
        output load_valid, load_data, load_last,
        output fetch_en, fetch_addr, stall, flush,
        input  load_ready, run_mode,
        input  instr, instr_valid, addr_fault
    );

    modport slave (
        input  load_valid, load_data, load_last,
        input  fetch_en, fetch_addr, stall, flush,
        output load_ready, run_mode,
        output instr, instr_valid, addr_fault
    );
endinterface

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x DATA_W storage, synchronous write, combinational read
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int PTR_W  = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    // Contents are never reset; the owner masks stale words with its loaded bits.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - instruction memory streamed in after reset, then serving registered fetches
module imem_loadable
    import imem_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 64,
    parameter int                ADDR_W    = 32,
    parameter bit                BYTE_ADDR = 1'b0,
    parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_DEFAULT)
) (
    input logic            clk,
    input logic            rst,
    imem_loadable_if.slave bus
);
    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    imem_state_e       state_q, state_d;
    logic [PTR_W-1:0]  load_ptr_q, load_ptr_d;
    logic [DEPTH-1:0]  loaded_q, loaded_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              addr_fault_q, addr_fault_d;

    logic              load_fire;
    logic              mem_we;
    logic [IDX_W-1:0]  fetch_idx;
    logic [PTR_W-1:0]  rd_idx;
    logic              idx_in_range;
    logic [DATA_W-1:0] rd_data;

    assign fetch_idx    = fetch_index(IDX_W'(bus.fetch_addr), BYTE_ADDR);
    assign idx_in_range = (fetch_idx < DEPTH_IDX);
    assign rd_idx       = fetch_idx[PTR_W-1:0];
    assign load_fire    = bus.load_valid && (state_q == ST_LOAD);

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (load_ptr_q),
        .wdata_i (bus.load_data),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d       = state_q;
        load_ptr_d    = load_ptr_q;
        loaded_d      = loaded_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        addr_fault_d  = addr_fault_q;
        mem_we        = 1'b0;

        case (state_q)
            ST_LOAD: begin
                instr_valid_d = 1'b0;
                addr_fault_d  = 1'b0;
                if (load_fire) begin
                    mem_we               = 1'b1;
                    loaded_d[load_ptr_q] = 1'b1;
                    load_ptr_d           = load_ptr_q + PTR_W'(1);
                    // A full array ends the load even without an explicit last marker.
                    if (bus.load_last || (load_ptr_q == LAST_PTR)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    instr_d       = NOP_WORD;
                    instr_valid_d = 1'b0;
                    addr_fault_d  = 1'b0;
                end else if (!bus.stall) begin
                    if (bus.fetch_en) begin
                        instr_valid_d = 1'b1;
                        if (!idx_in_range) begin
                            instr_d      = NOP_WORD;
                            addr_fault_d = 1'b1;
                        end else if (!loaded_q[rd_idx]) begin
                            instr_d      = NOP_WORD;
                            addr_fault_d = 1'b0;
                        end else begin
                            instr_d      = rd_data;
                            addr_fault_d = 1'b0;
                        end
                    end else begin
                        instr_valid_d = 1'b0;
                        addr_fault_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOAD;
            load_ptr_q    <= '0;
            loaded_q      <= '0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            addr_fault_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_ptr_q    <= load_ptr_d;
            loaded_q      <= loaded_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            addr_fault_q  <= addr_fault_d;
        end
    end

    assign bus.load_ready  = (state_q == ST_LOAD);
    assign bus.run_mode    = (state_q == ST_RUN);
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.addr_fault  = addr_fault_q;

endmodule

// File: tb/tb_imem_loadable.sv
// tb/tb_imem_loadable.sv - scoreboard bench for imem_loadable, word- and byte-addressed instances side by side
module tb_imem_loadable;
    localparam int              DATA_W = 32;
    localparam int              DEPTH  = 64;
    localparam int              ADDR_W = 40;
    localparam logic [DATA_W-1:0] NOP  = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              lv, ll, fe, st, fl;
    logic [DATA_W-1:0] ld;
    logic [ADDR_W-1:0] fidx;
    logic [1:0]        flow;

    imem_loadable_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b0 ();
    imem_loadable_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b1 ();

    assign b0.load_valid = lv;
    assign b0.load_data  = ld;
    assign b0.load_last  = ll;
    assign b0.fetch_en   = fe;
    assign b0.fetch_addr = fidx;
    assign b0.stall      = st;
    assign b0.flush      = fl;
    assign b1.load_valid = lv;
    assign b1.load_data  = ld;
    assign b1.load_last  = ll;
    assign b1.fetch_en   = fe;
    assign b1.fetch_addr = {fidx[ADDR_W-3:0], flow};
    assign b1.stall      = st;
    assign b1.flush      = fl;

    imem_loadable #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYTE_ADDR(1'b0), .NOP_WORD(NOP))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    imem_loadable #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYTE_ADDR(1'b1), .NOP_WORD(NOP))
        dut1 (.clk(clk), .rst(rst), .bus(b1));

    // Reference: program image, which words were written, and whether the load phase is over.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                ref_loaded [DEPTH];
    bit                ref_run;
    int                ref_ptr;
    logic [DATA_W-1:0] m_instr;
    bit                m_valid, m_fault;

    logic [DATA_W:0]   q0 [$];
    logic [DATA_W:0]   q1 [$];
    logic [DATA_W:0]   e0, e1;
    logic [DATA_W-1:0] prog [4];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (b0.instr_valid === 1'b1) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected instr_valid", 64'd1, 64'd0);
            end else begin
                e0 = q0.pop_front();
                check("dut0 fetch {fault,instr}", 64'({b0.addr_fault, b0.instr}), 64'(e0));
            end
        end
        if (b1.instr_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected instr_valid", 64'd1, 64'd0);
            end else begin
                e1 = q1.pop_front();
                check("dut1 fetch {fault,instr}", 64'({b1.addr_fault, b1.instr}), 64'(e1));
            end
        end
    end

    // Apply the behavioural rules to the current inputs, queue any result, advance one clock.
    task automatic step();
        if (rst) begin
            ref_run = 1'b0;
            ref_ptr = 0;
            foreach (ref_loaded[i]) ref_loaded[i] = 1'b0;
            m_instr = NOP;
            m_valid = 1'b0;
            m_fault = 1'b0;
        end else if (!ref_run) begin
            if (lv) begin
                ref_mem[ref_ptr]    = ld;
                ref_loaded[ref_ptr] = 1'b1;
                if (ll || ref_ptr == DEPTH - 1) ref_run = 1'b1;
                ref_ptr++;
            end
            m_valid = 1'b0;
            m_fault = 1'b0;
        end else if (fl) begin
            m_instr = NOP;
            m_valid = 1'b0;
            m_fault = 1'b0;
        end else if (!st) begin
            if (fe) begin
                m_valid = 1'b1;
                if (fidx >= ADDR_W'(DEPTH)) begin
                    m_instr = NOP;
                    m_fault = 1'b1;
                end else begin
                    m_fault = 1'b0;
                    m_instr = ref_loaded[int'(fidx)] ? ref_mem[int'(fidx)] : NOP;
                end
            end else begin
                m_valid = 1'b0;
                m_fault = 1'b0;
            end
        end
        if (m_valid) begin
            q0.push_back({m_fault, m_instr});
            q1.push_back({m_fault, m_instr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lv = 1'b0; ll = 1'b0; ld = '0;
        fe = 1'b0; st = 1'b0; fl = 1'b0;
        fidx = '0; flow = 2'd0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] idx, input logic [1:0] low);
        fe = 1'b1; fidx = idx; flow = low;
        step();
        fe = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic rand_run(input int n);
        for (int k = 0; k < n; k++) begin
            fe   = ($urandom_range(0, 3) != 0);
            st   = ($urandom_range(0, 4) == 0);
            fl   = ($urandom_range(0, 9) == 0);
            lv   = ($urandom_range(0, 7) == 0);
            ld   = $urandom;
            flow = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       fidx = 40'h1_0000_0000 + ADDR_W'($urandom_range(0, 3));
                1:       fidx = ADDR_W'($urandom_range(DEPTH, 4000));
                default: fidx = ADDR_W'($urandom_range(0, DEPTH + 3));
            endcase
            step();
        end
        idle();
        step();
    endtask

    initial begin
        prog[0] = 32'hE001_0000;
        prog[1] = 32'h5041_0400;
        prog[2] = 32'h0000_0000;
        prog[3] = 32'h7102_0400;

        do_reset();
        rst = 1'b1;
        step();
        check("reset load_ready", 64'(b0.load_ready), 64'd1);
        check("reset run_mode", 64'(b0.run_mode), 64'd0);
        check("reset instr", 64'(b0.instr), 64'(NOP));
        check("reset instr_valid", 64'(b0.instr_valid), 64'd0);
        check("reset addr_fault", 64'(b0.addr_fault), 64'd0);
        check("reset dut1 instr_valid", 64'(b1.instr_valid), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            lv = 1'b1; ld = prog[i]; ll = (i == 3);
            step();
            if (i == 2) check("load_ready before last", 64'(b0.load_ready), 64'd1);
        end
        idle();
        check("load_ready after last", 64'(b0.load_ready), 64'd0);
        check("run_mode after last", 64'(b0.run_mode), 64'd1);
        check("dut1 run_mode after last", 64'(b1.run_mode), 64'd1);

        for (int i = 0; i < 4; i++) fetch(ADDR_W'(i), 2'd0);
        fetch(40'd3, 2'd1);
        fetch(40'd10, 2'd2);
        fetch(40'd64, 2'd0);
        fetch(40'h1_0000_0000, 2'd0);
        fetch(40'h1_0000_0001, 2'd3);
        step();

        fetch(40'd1, 2'd0);
        st = 1'b1; fe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fidx = ADDR_W'($urandom_range(0, 3));
            step();
        end
        check("stall holds instr", 64'(b0.instr), 64'h5041_0400);
        check("stall holds instr_valid", 64'(b0.instr_valid), 64'd1);
        fl = 1'b1;
        step();
        check("flush over stall instr", 64'(b0.instr), 64'(NOP));
        check("flush over stall instr_valid", 64'(b0.instr_valid), 64'd0);
        check("flush dut1 instr_valid", 64'(b1.instr_valid), 64'd0);
        idle();
        rand_run(200);

        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            lv = 1'b1; ld = $urandom; ll = 1'b0;
            step();
            if (i == DEPTH - 2) check("load_ready before full", 64'(b0.load_ready), 64'd1);
        end
        check("run_mode after full load", 64'(b0.run_mode), 64'd1);
        lv = 1'b1; ld = 32'hDEAD_BEEF;
        step();
        check("load_ready stays low in run", 64'(b0.load_ready), 64'd0);
        idle();
        fetch(40'd0, 2'd0);
        fetch(ADDR_W'(DEPTH - 1), 2'd3);
        fetch(ADDR_W'(DEPTH), 2'd0);
        rand_run(150);

        do_reset();
        for (int i = 0; i < 2; i++) begin
            lv = 1'b1; ld = prog[i]; ll = 1'b0;
            step();
        end
        lv = 1'b1; ld = prog[2];
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        check("reset mid-load load_ready", 64'(b0.load_ready), 64'd1);
        lv = 1'b1; ld = 32'hAAAA_5555; ll = 1'b1;
        step();
        idle();
        check("reload run_mode", 64'(b0.run_mode), 64'd1);
        fetch(40'd1, 2'd0);
        fetch(40'd0, 2'd2);
        rand_run(60);

        step();
        step();
        check("scoreboard drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised successor to the fixed-program instruction memory.
- Program is streamed in after reset through a valid/ready load port, not hard-wired.
- Then serves registered fetches with stall, flush, out-of-range fault and NOP-on-unloaded handling.
- Sits between the PC/fetch stage and the decode pipeline register.

Parameters:
DATA_W, 32, instruction word width
DEPTH, 64, number of instruction words (≥2)
ADDR_W, 32, width of fetch_addr
BYTE_ADDR, 0, 0: fetch_addr is a word index; 1: index = fetch_addr >> 2 (low 2 bits ignored)
NOP_WORD, 0, word returned for flushed, unloaded or out-of-range fetches

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
load_valid  input  1  load word present
load_data  input  DATA_W  instruction word to store
load_last  input  1  marks final word of program
load_ready  output  1  block accepts load word (high only in LOAD state)
run_mode  output  1  high once program load complete (RUN state)
fetch_en  input  1  fetch request this cycle
fetch_addr  input  ADDR_W  fetch address
stall  input  1  hold fetch outputs
flush  input  1  kill in-flight fetch
instr  output  DATA_W  fetched instruction, registered
instr_valid  output  1  instr is a new fetch result this cycle
addr_fault  output  1  current instr came from out-of-range address

Behaviour:
- States: LOAD, RUN. Reset → LOAD.
- Reset values:
  - load_ptr=0, loaded[DEPTH-1:0]=0
  - instr=NOP_WORD, instr_valid=0, addr_fault=0, run_mode=0
  - Array contents are not cleared; the loaded bits mask them.
- load_ready = (state==LOAD); run_mode = (state==RUN). Both decoded from the registered state.
- LOAD:
  - On load_valid && load_ready: mem[load_ptr]<=load_data, loaded[load_ptr]<=1, load_ptr++.
  - Go to RUN when an accepted word has load_last=1 or load_ptr==DEPTH-1. Both together cause a single transition.
  - fetch_en ignored; instr_valid=0.
- RUN:
  - Load port ignored; load_ptr frozen. No return to LOAD except via rst.
- Fetch, RUN only, 1-cycle latency. Priority: rst > flush > stall > fetch_en.
  - flush: instr<=NOP_WORD, instr_valid<=0, addr_fault<=0. Flush wins over simultaneous stall.
  - stall (no flush): instr, instr_valid, addr_fault all hold their values.
  - fetch_en: idx = BYTE_ADDR ? fetch_addr>>2 : fetch_addr; instr_valid<=1.
    - idx ≥ DEPTH: instr<=NOP_WORD, addr_fault<=1.
    - !loaded[idx]: instr<=NOP_WORD, addr_fault<=0.
    - Otherwise: instr<=mem[idx], addr_fault<=0.
  - !fetch_en: instr_valid<=0, addr_fault<=0, instr holds.
- Reset mid-load or mid-run: back to LOAD next cycle, all loaded bits cleared, any partial program discarded.
- Width rule: idx compared at full ADDR_W width; no truncation or wrap of high address bits.

Decomposition:
- Package imem_pkg:
  - state enum {LOAD, RUN}
  - default NOP constant
  - function computing idx from address and BYTE_ADDR
- One sub-module, imem_array:
  - DEPTH×DATA_W storage with a synchronous write port and a combinational read port.
  - Control FSM, loaded bits and output registers stay in the top level.

Test Plan:
- Reset, stream 4 words 0xE0010000, 0x50410400, 0x00000000, 0x71020400 with load_last on the 4th. Expect load_ready falls and run_mode rises the cycle after the 4th accept. Fetch idx 0..3 returns the same words, each 1 cycle after fetch_en, instr_valid=1.
- After that load, fetch idx 10 (in range, unloaded) → instr=0, addr_fault=0. Fetch idx 64 (DEPTH=64) → instr=0, addr_fault=1. Fetch idx 0x1_0000_0000-wide aliases are not wrapped.
- Load DEPTH words with load_last never asserted → RUN entered after word 63. A 65th load_valid is not accepted (load_ready=0) and does not overwrite mem[0].
- In RUN: fetch idx 1, then assert stall for 3 cycles while fetch_addr changes → instr stays 0x50410400 and instr_valid held. Then assert flush together with stall → instr=0, instr_valid=0.
- BYTE_ADDR=1: fetch_addr 0x0C → word 3; fetch_addr 0x0D → word 3.
- Assert rst after 2 of 4 words loaded, reload 1 word with load_last → fetch idx 1 returns NOP_WORD, confirming loaded bits were cleared.
